xif_offload: RTL and testbench
==============================

Name: xif_offload

Overview:
Core-side initiator of the eXtension (X-IF) issue/commit/result interface. It takes one custom instruction from the core decode stage together with its source operands. It issues the instruction to the coprocessor, commits or kills it, then collects the result and drives a register-file write-back port. Only one transaction is outstanding at a time, and the memory interface is not handled by this block.

Parameters:
X_NUM_RS, 2, register operands forwarded per instruction
X_ID_WIDTH, 4, transaction ID width
X_RFR_WIDTH, 32, operand width
X_RFW_WIDTH, 32, result data width
TIMEOUT_CYCLES, 1024, maximum cycles in WAIT_RESULT; 0 disables the timeout
TIMEOUT_EXCCODE, 6'h3F, exception code reported on timeout

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
offload_valid / offload_ready  in/out  1/1  core request handshake
offload_instr  in  32  instruction word
offload_rs / offload_rs_valid  in  X_NUM_RS*X_RFR_WIDTH / X_NUM_RS  operands and per-operand valids
offload_kill  in  1  core flush request
offload_done / offload_illegal / offload_exc  out  1/1/1  one-cycle completion pulses
offload_exccode  out  6  exception code, valid with offload_exc
rf_we / rf_waddr / rf_wdata  out  1/5/X_RFW_WIDTH  register-file write pulse, address, data
issue_valid / issue_ready  out/in  1/1  issue handshake
issue_req_instr / issue_req_id / issue_req_mode  out  32/X_ID_WIDTH/2  issue request; mode is 2'b11
issue_req_rs / issue_req_rs_valid  out  X_NUM_RS*X_RFR_WIDTH / X_NUM_RS  operands
issue_resp_accept / issue_resp_writeback  in  1/1  sampled on issue handshake
commit_valid / commit_id / commit_kill  out  1/X_ID_WIDTH/1  commit strobe, ID, kill flag
result_valid / result_ready  in/out  1/1  result handshake
result_id / result_data / result_rd / result_we  in  X_ID_WIDTH/X_RFW_WIDTH/5/1  result payload
result_exc / result_exccode  in  1/6  result exception

Behaviour:
- Clocking/reset: one clock clk_i; reset rst_ni asynchronous active-low. On reset: state IDLE, id counter 0, every output 0 except offload_ready=1. Reset mid-transaction abandons the transaction and sends no commit.
- States: IDLE, ISSUE, COMMIT, WAIT_RESULT.
- IDLE: offload_ready=1. When offload_valid is high, latch instr/rs/rs_valid, clear kill_pend, go to ISSUE. issue_valid rises in the next cycle.
- ISSUE: issue_valid=1. Request fields stay stable until issue_ready; issue_valid is never retracted. On the handshake: latch accept_q and wb_q, increment id (wraps modulo 2^X_ID_WIDTH), go to COMMIT.
- COMMIT: one-cycle commit_valid with commit_id equal to the issued id. commit_kill = kill_pend | offload_kill | !accept_q.
  - If !accept_q: pulse offload_illegal next cycle, go to IDLE.
  - Else if killed or !wb_q: pulse offload_done, go to IDLE.
  - Else go to WAIT_RESULT.
- offload_kill in ISSUE sets kill_pend and has effect at commit. offload_kill in IDLE or WAIT_RESULT is ignored, because the instruction is already committed by WAIT_RESULT.
- WAIT_RESULT: result_ready=1 and the cycle counter runs.
  - result_valid with matching ID and result_exc=1: next cycle, offload_exc=1 with offload_exccode=result_exccode and no rf write. Go to IDLE.
  - result_valid with matching ID and result_exc=0: next cycle, rf_we = result_we & (result_rd != 0), rf_waddr=result_rd, rf_wdata=result_data, offload_done=1. Go to IDLE.
  - Result with a non-matching ID: consumed and dropped, no pulse, state unchanged.
  - Counter reaching TIMEOUT_CYCLES (when nonzero): offload_exc=1 with offload_exccode=TIMEOUT_EXCCODE, go to IDLE.
  - A result arriving in the same cycle as the timeout wins.
- Latency with zero-wait coprocessor: offload_valid at T0, issue_valid at T1, commit at T2, result_ready from T3, result at Tn, rf_we/offload_done at Tn+1.
- Output timing: all completion and rf outputs are registered one-cycle pulses. issue_*, commit_* and result_ready are decoded from state and latched registers.
- Results arriving outside WAIT_RESULT see result_ready=0 and are not consumed.

Decomposition:
- Shared package xif_pkg holds: xif_state_e (IDLE/ISSUE/COMMIT/WAIT_RESULT), custom opcode constants (RMLD 7'h08, RMST 7'h09, TEST 7'h0a), XIF_MODE_M=2'b11, TIMEOUT_EXCCODE default.
- Single module with no sub-module; the timeout counter and id counter stay inline.

Test Plan:
- TEST opcode 0x0a, rd=5, coprocessor accepts with writeback and returns 32'hDEADBEEF, id 0 -> commit_id=0, commit_kill=0; rf_we=1, rf_waddr=5, rf_wdata=32'hDEADBEEF and offload_done pulse at Tn+1.
- Coprocessor rejects (accept=0) -> commit_kill=1, offload_illegal one pulse, no rf_we, back in IDLE with offload_ready=1.
- offload_kill asserted while issue_ready is held low 3 cycles -> issue_valid and fields stable throughout; commit_kill=1, offload_done pulse, result_ready never asserted.
- 17 back-to-back accepted instructions with X_ID_WIDTH=4 -> issue_req_id sequence 0..15,0; result with rd=0 gives rf_we=0.
- In WAIT_RESULT, result with wrong id 3 is dropped, then correct id returns data 32'h12345678 -> single rf_we with 32'h12345678.
- TIMEOUT_CYCLES=8, no result -> offload_exc with exccode 6'h3F after 8 cycles; result with result_exc=1, code 6'h05 -> offload_exc with offload_exccode 6'h05; rst_ni low mid-WAIT_RESULT -> all outputs 0, offload_ready=1.

Source files
------------

// File: rtl/xif_pkg.sv
// Shared types and constants for the X-IF offload initiator.
package xif_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        COMMIT,
        WAIT_RESULT
    } xif_state_e;

    localparam logic [6:0] OPC_RMLD = 7'h08;
    localparam logic [6:0] OPC_RMST = 7'h09;
    localparam logic [6:0] OPC_TEST = 7'h0a;

    localparam logic [1:0] XIF_MODE_M          = 2'b11;
    localparam logic [5:0] XIF_TIMEOUT_EXCCODE = 6'h3F;

endpackage

// File: rtl/xif_offload_if.sv
// X-IF issue/commit/result channel between the core-side initiator and the coprocessor.
interface xif_offload_if #(
    parameter int unsigned X_NUM_RS    = 2,
    parameter int unsigned X_ID_WIDTH  = 4,
    parameter int unsigned X_RFR_WIDTH = 32,
    parameter int unsigned X_RFW_WIDTH = 32
);
    logic                                   issue_valid;
    logic                                   issue_ready;
    logic [31:0]                            issue_req_instr;
    logic [X_ID_WIDTH-1:0]                  issue_req_id;
    logic [1:0]                             issue_req_mode;
    logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0]   issue_req_rs;
    logic [X_NUM_RS-1:0]                    issue_req_rs_valid;
    logic                                   issue_resp_accept;
    logic                                   issue_resp_writeback;

    logic                                   commit_valid;
    logic [X_ID_WIDTH-1:0]                  commit_id;
    logic                                   commit_kill;

    logic                                   result_valid;
    logic                                   result_ready;
    logic [X_ID_WIDTH-1:0]                  result_id;
    logic [X_RFW_WIDTH-1:0]                 result_data;
    logic [4:0]                             result_rd;
    logic                                   result_we;
    logic                                   result_exc;
    logic [5:0]                             result_exccode;

    modport master (
        output issue_valid, issue_req_instr, issue_req_id, issue_req_mode,
               issue_req_rs, issue_req_rs_valid, commit_valid, commit_id,
               commit_kill, result_ready,
        input  issue_ready, issue_resp_accept, issue_resp_writeback,
               result_valid, result_id, result_data, result_rd, result_we,
               result_exc, result_exccode
    );

    modport slave (
        input  issue_valid, issue_req_instr, issue_req_id, issue_req_mode,
               issue_req_rs, issue_req_rs_valid, commit_valid, commit_id,
               commit_kill, result_ready,
        output issue_ready, issue_resp_accept, issue_resp_writeback,
               result_valid, result_id, result_data, result_rd, result_we,
               result_exc, result_exccode
    );

endinterface

// File: rtl/xif_offload.sv
// Core-side X-IF initiator: issues one custom instruction, commits or kills it,
// and turns the coprocessor result into a register-file write or completion pulse.
module xif_offload
    import xif_pkg::*;
#(
    parameter int unsigned X_NUM_RS        = 2,
    parameter int unsigned X_ID_WIDTH      = 4,
    parameter int unsigned X_RFR_WIDTH     = 32,
    parameter int unsigned X_RFW_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES  = 1024,
    parameter logic [5:0]  TIMEOUT_EXCCODE = XIF_TIMEOUT_EXCCODE
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 offload_valid,
    output logic                                 offload_ready,
    input  logic [31:0]                          offload_instr,
    input  logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0] offload_rs,
    input  logic [X_NUM_RS-1:0]                  offload_rs_valid,
    input  logic                                 offload_kill,
    output logic                                 offload_done,
    output logic                                 offload_illegal,
    output logic                                 offload_exc,
    output logic [5:0]                           offload_exccode,
    output logic                                 rf_we,
    output logic [4:0]                           rf_waddr,
    output logic [X_RFW_WIDTH-1:0]               rf_wdata,
    xif_offload_if.master                        xif
);

    xif_state_e                           r_state;
    logic [31:0]                          r_instr;
    logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0] r_rs;
    logic [X_NUM_RS-1:0]                  r_rs_valid;
    logic                                 r_kill_pend;
    logic                                 r_accept;
    logic                                 r_wb;
    logic [X_ID_WIDTH-1:0]                r_id;
    logic [X_ID_WIDTH-1:0]                r_cid;
    logic [31:0]                          r_cnt;
    logic                                 r_done;
    logic                                 r_illegal;
    logic                                 r_exc;
    logic [5:0]                           r_exccode;
    logic                                 r_rf_we;
    logic [4:0]                           r_waddr;
    logic [X_RFW_WIDTH-1:0]               r_wdata;

    logic w_commit;
    logic w_kill;
    logic w_hit;

    assign w_commit = (r_state == COMMIT);
    assign w_kill   = r_kill_pend | offload_kill;
    assign w_hit    = xif.result_ready & xif.result_valid & (xif.result_id == r_cid);

    assign offload_ready          = (r_state == IDLE);
    assign xif.issue_valid        = (r_state == ISSUE);
    assign xif.issue_req_instr    = r_instr;
    assign xif.issue_req_id       = r_id;
    assign xif.issue_req_mode     = xif.issue_valid ? XIF_MODE_M : 2'b00;
    assign xif.issue_req_rs       = r_rs;
    assign xif.issue_req_rs_valid = r_rs_valid;
    assign xif.commit_valid       = w_commit;
    assign xif.commit_id          = r_cid;
    assign xif.commit_kill        = w_commit & (w_kill | ~r_accept);
    assign xif.result_ready       = (r_state == WAIT_RESULT);

    assign offload_done    = r_done;
    assign offload_illegal = r_illegal;
    assign offload_exc     = r_exc;
    assign offload_exccode = r_exccode;
    assign rf_we           = r_rf_we;
    assign rf_waddr        = r_waddr;
    assign rf_wdata        = r_wdata;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_instr     <= '0;
            r_rs        <= '0;
            r_rs_valid  <= '0;
            r_kill_pend <= 1'b0;
            r_accept    <= 1'b0;
            r_wb        <= 1'b0;
            r_id        <= '0;
            r_cid       <= '0;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_illegal   <= 1'b0;
            r_exc       <= 1'b0;
            r_exccode   <= '0;
            r_rf_we     <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
        end else begin
            // completion outputs are single-cycle pulses
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_exc     <= 1'b0;
            r_exccode <= '0;
            r_rf_we   <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            case (r_state)
                IDLE: begin
                    if (offload_valid) begin
                        r_instr     <= offload_instr;
                        r_rs        <= offload_rs;
                        r_rs_valid  <= offload_rs_valid;
                        r_kill_pend <= 1'b0;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (offload_kill) r_kill_pend <= 1'b1;
                    if (xif.issue_ready) begin
                        r_accept <= xif.issue_resp_accept;
                        r_wb     <= xif.issue_resp_writeback;
                        r_cid    <= r_id;
                        r_id     <= r_id + 1'b1;
                        r_state  <= COMMIT;
                    end
                end
                COMMIT: begin
                    r_cnt <= '0;
                    if (!r_accept) begin
                        r_illegal <= 1'b1;
                        r_state   <= IDLE;
                    end else if (w_kill || !r_wb) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_state <= WAIT_RESULT;
                    end
                end
                WAIT_RESULT: begin
                    // a matching result takes priority over a timeout in the same cycle
                    if (w_hit) begin
                        if (xif.result_exc) begin
                            r_exc     <= 1'b1;
                            r_exccode <= xif.result_exccode;
                        end else begin
                            r_rf_we <= xif.result_we & (xif.result_rd != 5'd0);
                            r_waddr <= xif.result_rd;
                            r_wdata <= xif.result_data;
                            r_done  <= 1'b1;
                        end
                        r_state <= IDLE;
                    end else if (TIMEOUT_CYCLES != 0 && r_cnt == TIMEOUT_CYCLES - 1) begin
                        r_exc     <= 1'b1;
                        r_exccode <= TIMEOUT_EXCCODE;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xif_offload.sv
// Directed bench for xif_offload: vector table for single transactions plus
// hand-written sequences for stall/kill, stray results, timeout, exception and reset.
module tb_xif_offload;
    import xif_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             offload_valid = 1'b0;
    logic             offload_ready;
    logic [31:0]      offload_instr = '0;
    logic [1:0][31:0] offload_rs = '0;
    logic [1:0]       offload_rs_valid = '0;
    logic             offload_kill = 1'b0;
    logic             offload_done, offload_illegal, offload_exc;
    logic [5:0]       offload_exccode;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [31:0]      rf_wdata;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] exp_id = '0;

    always #5 clk = ~clk;

    xif_offload_if #(.X_NUM_RS(2), .X_ID_WIDTH(4), .X_RFR_WIDTH(32), .X_RFW_WIDTH(32)) xif ();

    xif_offload #(
        .X_NUM_RS(2), .X_ID_WIDTH(4), .X_RFR_WIDTH(32), .X_RFW_WIDTH(32),
        .TIMEOUT_CYCLES(8), .TIMEOUT_EXCCODE(6'h3F)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .offload_valid(offload_valid), .offload_ready(offload_ready),
        .offload_instr(offload_instr), .offload_rs(offload_rs),
        .offload_rs_valid(offload_rs_valid), .offload_kill(offload_kill),
        .offload_done(offload_done), .offload_illegal(offload_illegal),
        .offload_exc(offload_exc), .offload_exccode(offload_exccode),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .xif(xif.master)
    );

    typedef struct {
        logic [31:0] instr;
        logic        accept, wb, kill;
        logic [31:0] rdata;
        logic [4:0]  rrd;
        logic        rwe;
        logic        e_kill, e_done, e_ill, e_rfwe;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] mk_instr(input logic [6:0] opc, input logic [4:0] rd);
        return {7'h00, 5'd2, 5'd1, 3'b000, rd, opc};
    endfunction

    task automatic start_issue(input logic [31:0] instr, input logic acc, input logic wb);
        offload_valid = 1'b1; offload_instr = instr;
        offload_rs = {32'hBBBB_0002, 32'hAAAA_0001}; offload_rs_valid = 2'b11;
        @(negedge clk); check("offload_ready", offload_ready, 1);
        tick(); offload_valid = 1'b0; offload_instr = '0;
        xif.issue_ready = 1'b1; xif.issue_resp_accept = acc; xif.issue_resp_writeback = wb;
        @(negedge clk);
        check("issue_valid", xif.issue_valid, 1);
        check("issue_req_id", xif.issue_req_id, exp_id);
        check("issue_req_instr", xif.issue_req_instr, instr);
        check("issue_req_mode", xif.issue_req_mode, 2'b11);
        check("issue_req_rs", xif.issue_req_rs, {32'hBBBB_0002, 32'hAAAA_0001});
        tick(); xif.issue_ready = 1'b0;
    endtask

    // Leaves the bench at the first WAIT_RESULT cycle; returns the committed id.
    task automatic issue_to_wait(output logic [3:0] id);
        start_issue(mk_instr(OPC_RMLD, 5'd3), 1'b1, 1'b1);
        @(negedge clk);
        check("commit_valid", xif.commit_valid, 1);
        check("commit_id", xif.commit_id, exp_id);
        check("commit_kill", xif.commit_kill, 0);
        id = exp_id; exp_id++;
        tick();
    endtask

    task automatic run_txn(input vec_t v);
        start_issue(v.instr, v.accept, v.wb);
        offload_kill = v.kill;
        @(negedge clk);
        check("commit_valid", xif.commit_valid, 1);
        check("commit_id", xif.commit_id, exp_id);
        check("commit_kill", xif.commit_kill, v.e_kill);
        tick(); offload_kill = 1'b0;
        if (v.accept && v.wb && !v.kill) begin
            xif.result_valid = 1'b1; xif.result_id = exp_id; xif.result_data = v.rdata;
            xif.result_rd = v.rrd; xif.result_we = v.rwe; xif.result_exc = 1'b0;
            @(negedge clk); check("result_ready", xif.result_ready, 1);
            tick(); xif.result_valid = 1'b0;
        end else begin
            @(negedge clk); check("result_ready_idle", xif.result_ready, 0);
        end
        exp_id++;
        check("offload_done", offload_done, v.e_done);
        check("offload_illegal", offload_illegal, v.e_ill);
        check("offload_exc", offload_exc, 0);
        check("rf_we", rf_we, v.e_rfwe);
        check("rf_waddr", rf_waddr, v.e_waddr);
        check("rf_wdata", rf_wdata, v.e_wdata);
        check("ready_after", offload_ready, 1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        logic [3:0] id;
        logic [31:0] hold_instr;
        logic [3:0] hold_id;
        int cnt;
        int rr_seen;

        xif.issue_ready = 1'b0; xif.issue_resp_accept = 1'b0; xif.issue_resp_writeback = 1'b0;
        xif.result_valid = 1'b0; xif.result_id = '0; xif.result_data = '0;
        xif.result_rd = '0; xif.result_we = 1'b0; xif.result_exc = 1'b0; xif.result_exccode = '0;

        //          instr                        acc  wb  kil rdata          rrd   rwe   ekil edn eil erfwe ewaddr e_wdata
        vecs[0] = '{mk_instr(OPC_TEST, 5'd5),  1, 1, 0, 32'hDEADBEEF, 5'd5, 1,  0, 1, 0, 1, 5'd5, 32'hDEADBEEF};
        vecs[1] = '{mk_instr(OPC_TEST, 5'd6),  0, 1, 0, 32'h0,        5'd0, 0,  1, 0, 1, 0, 5'd0, 32'h0};
        vecs[2] = '{mk_instr(OPC_RMST, 5'd0),  1, 0, 0, 32'h0,        5'd0, 0,  0, 1, 0, 0, 5'd0, 32'h0};
        vecs[3] = '{mk_instr(OPC_RMLD, 5'd8),  1, 1, 1, 32'h0,        5'd0, 0,  1, 1, 0, 0, 5'd0, 32'h0};
        vecs[4] = '{mk_instr(OPC_TEST, 5'd0),  1, 1, 0, 32'h00001111, 5'd0, 1,  0, 1, 0, 0, 5'd0, 32'h00001111};
        vecs[5] = '{mk_instr(OPC_TEST, 5'd7),  1, 1, 0, 32'h00002222, 5'd7, 0,  0, 1, 0, 0, 5'd7, 32'h00002222};
        vecs[6] = '{mk_instr(OPC_RMLD, 5'd9),  1, 1, 0, 32'h0000A5A5, 5'd9, 1,  0, 1, 0, 1, 5'd9, 32'h0000A5A5};

        // reset state
        #2;
        @(negedge clk);
        check("rst_offload_ready", offload_ready, 1);
        check("rst_issue_valid", xif.issue_valid, 0);
        check("rst_issue_id", xif.issue_req_id, 0);
        check("rst_result_ready", xif.result_ready, 0);
        check("rst_rf_we", rf_we, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run_txn(vecs[i]);

        // kill while issue is stalled: request stays stable, kill lands at commit
        offload_valid = 1'b1; offload_instr = mk_instr(OPC_TEST, 5'd4);
        offload_rs = {32'h1, 32'h2}; offload_rs_valid = 2'b01;
        tick(); offload_valid = 1'b0; offload_kill = 1'b1;
        hold_instr = mk_instr(OPC_TEST, 5'd4); hold_id = exp_id; rr_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_issue_valid", xif.issue_valid, 1);
            check("stall_instr", xif.issue_req_instr, hold_instr);
            check("stall_id", xif.issue_req_id, hold_id);
            check("stall_mode", xif.issue_req_mode, 2'b11);
            tick(); offload_kill = 1'b0;
        end
        xif.issue_ready = 1'b1; xif.issue_resp_accept = 1'b1; xif.issue_resp_writeback = 1'b1;
        tick(); xif.issue_ready = 1'b0;
        @(negedge clk);
        check("kill_commit_valid", xif.commit_valid, 1);
        check("kill_commit_kill", xif.commit_kill, 1);
        exp_id++;
        for (int k = 0; k < 3; k++) begin
            if (xif.result_ready) rr_seen++;
            tick(); @(negedge clk);
            if (k == 0) begin
                check("kill_done", offload_done, 1);
                check("kill_rf_we", rf_we, 0);
            end
        end
        check("kill_result_ready_never", rr_seen, 0);
        tick();

        // stray result with wrong id is consumed without effect
        issue_to_wait(id);
        xif.result_valid = 1'b1; xif.result_id = 4'd3; xif.result_data = 32'hBAD0BAD0;
        xif.result_rd = 5'd10; xif.result_we = 1'b1; xif.result_exc = 1'b0;
        tick();
        xif.result_id = id; xif.result_data = 32'h12345678;
        @(negedge clk);
        check("stray_no_done", offload_done, 0);
        check("stray_no_rf_we", rf_we, 0);
        check("stray_still_waiting", xif.result_ready, 1);
        tick(); xif.result_valid = 1'b0;
        @(negedge clk);
        check("match_rf_we", rf_we, 1);
        check("match_rf_waddr", rf_waddr, 5'd10);
        check("match_rf_wdata", rf_wdata, 32'h12345678);
        check("match_done", offload_done, 1);
        tick(); @(negedge clk);
        check("match_single_rf_we", rf_we, 0);
        tick();

        // timeout after 8 waiting cycles
        issue_to_wait(id);
        cnt = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (offload_exc) break;
            if (xif.result_ready) cnt++;
            tick();
        end
        check("timeout_exc", offload_exc, 1);
        check("timeout_cycles", cnt, 8);
        check("timeout_exccode", offload_exccode, 6'h3F);
        check("timeout_no_rf_we", rf_we, 0);
        tick();

        // result with exception
        issue_to_wait(id);
        xif.result_valid = 1'b1; xif.result_id = id; xif.result_data = 32'h55;
        xif.result_rd = 5'd4; xif.result_we = 1'b1; xif.result_exc = 1'b1; xif.result_exccode = 6'h05;
        tick(); xif.result_valid = 1'b0; xif.result_exc = 1'b0; xif.result_exccode = '0;
        @(negedge clk);
        check("exc_pulse", offload_exc, 1);
        check("exc_code", offload_exccode, 6'h05);
        check("exc_no_rf_we", rf_we, 0);
        check("exc_no_done", offload_done, 0);
        tick();

        // reset while waiting for a result
        issue_to_wait(id);
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst_ready", offload_ready, 1);
        check("mrst_result_ready", xif.result_ready, 0);
        check("mrst_commit_valid", xif.commit_valid, 0);
        check("mrst_issue_valid", xif.issue_valid, 0);
        check("mrst_issue_id", xif.issue_req_id, 0);
        check("mrst_issue_instr", xif.issue_req_instr, 0);
        check("mrst_pulses", {offload_done, offload_illegal, offload_exc, rf_we}, 4'b0000);
        check("mrst_exccode", offload_exccode, 0);
        check("mrst_wdata", rf_wdata, 0);
        tick(); rst_n = 1'b1; exp_id = '0;
        tick();

        // 17 back-to-back transactions: ids walk 0..15 and wrap to 0
        for (int i = 0; i < 17; i++) run_txn(vecs[(i % 2 == 0) ? 0 : 4]);
        check("wrap_final_id", xif.issue_req_id, 4'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
